btn_input_unit: RTL and testbench



---
 rtl/btn_input_unit_pkg.sv | 29 ++
 rtl/btn_input_unit_btn_channel.sv | 157 +++++++++++++++
 rtl/btn_input_unit.sv | 40 ++++
 tb/tb_btn_input_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/btn_input_unit_pkg.sv
// Shared button definitions: bus indices, CLK_PLL-derived default timing and the
// repeat FSM state type used by every button channel.
package btn_input_unit_pkg;

   localparam int BTN_LEFT  = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_RIGHT = 2;
   localparam int BTN_UP    = 3;
   localparam int BTN_ENTER = 4;
   localparam int N_BTN_DEF = 5;

   // 50 MHz CLK_PLL: 1 ms debounce, 0.5 s to first repeat, 0.1 s between repeats
   localparam int CLK_PLL_HZ        = 50_000_000;
   localparam int DEB_CYCLES_DEF    = CLK_PLL_HZ / 1000;
   localparam int REPEAT_DELAY_DEF  = CLK_PLL_HZ / 2;
   localparam int REPEAT_PERIOD_DEF = CLK_PLL_HZ / 10;
   localparam logic [4:0] REPEAT_MASK_DEF = 5'b01111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_input_unit_btn_channel.sv
// One button channel: 2-flop synchroniser, counter debounce, press/release edge
// pulses and a timed auto-repeat FSM. All outputs come straight from flops.
module btn_channel
   import btn_input_unit_pkg::*;
#(
   parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_repeat_en,
   input  logic i_btn_raw_n,
   output logic o_held,
   output logic o_press,
   output logic o_release,
   output logic o_repeat,
   output logic o_event
);

   localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
   localparam int REP_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic [DEB_W-1:0] r_deb_cnt;
   logic             r_deb;
   logic             r_held;
   logic             r_press;
   logic             r_release;
   logic             r_repeat;
   logic             r_event;
   rep_state_e       r_state;
   logic [REP_W-1:0] r_rep_cnt;

   logic             w_differ;
   logic [DEB_W-1:0] w_deb_cnt_nxt;
   logic             w_deb_nxt;
   logic             w_press_evt;
   logic             w_release_evt;
   rep_state_e       w_state_nxt;
   logic [REP_W-1:0] w_rep_cnt_nxt;
   logic             w_repeat_pulse;

   // Synchroniser: resets to released (pad idles high)
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_btn_raw_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_differ = (~r_sync2) != r_deb;

   // Debounce: flip only after DEB_CYCLES consecutive disagreeing cycles
   always_comb begin
      w_deb_cnt_nxt = r_deb_cnt;
      w_deb_nxt     = r_deb;
      if (w_differ) begin
         if (r_deb_cnt == DEB_LAST) begin
            w_deb_nxt     = ~r_deb;
            w_deb_cnt_nxt = {DEB_W{1'b0}};
         end else begin
            w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
         end
      end else begin
         w_deb_cnt_nxt = {DEB_W{1'b0}};
      end
   end

   // Edges are taken between the debounced state and its registered copy
   assign w_press_evt   = r_deb & ~r_held;
   assign w_release_evt = ~r_deb & r_held;

   // Repeat FSM next state; release wins over a coincident terminal count
   always_comb begin
      w_state_nxt    = r_state;
      w_rep_cnt_nxt  = r_rep_cnt;
      w_repeat_pulse = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_press_evt && i_repeat_en) begin
               w_state_nxt   = ST_DELAY;
               w_rep_cnt_nxt = {REP_W{1'b0}};
            end else begin
               w_state_nxt   = ST_IDLE;
            end
         end
         ST_DELAY: begin
            if (w_release_evt) begin
               w_state_nxt   = ST_IDLE;
               w_rep_cnt_nxt = {REP_W{1'b0}};
            end else if (r_rep_cnt == DLY_LAST) begin
               w_state_nxt    = ST_REPEAT;
               w_rep_cnt_nxt  = {REP_W{1'b0}};
               w_repeat_pulse = 1'b1;
            end else begin
               w_rep_cnt_nxt  = r_rep_cnt + REP_W'(1);
            end
         end
         ST_REPEAT: begin
            if (w_release_evt) begin
               w_state_nxt   = ST_IDLE;
               w_rep_cnt_nxt = {REP_W{1'b0}};
            end else if (r_rep_cnt == PER_LAST) begin
               w_rep_cnt_nxt  = {REP_W{1'b0}};
               w_repeat_pulse = 1'b1;
            end else begin
               w_rep_cnt_nxt  = r_rep_cnt + REP_W'(1);
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_rep_cnt_nxt = {REP_W{1'b0}};
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_deb_cnt <= {DEB_W{1'b0}};
         r_deb     <= 1'b0;
         r_held    <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
         r_event   <= 1'b0;
         r_state   <= ST_IDLE;
         r_rep_cnt <= {REP_W{1'b0}};
      end else begin
         r_deb_cnt <= w_deb_cnt_nxt;
         r_deb     <= w_deb_nxt;
         r_held    <= r_deb;
         r_press   <= w_press_evt;
         r_release <= w_release_evt;
         r_repeat  <= w_repeat_pulse;
         r_event   <= w_press_evt | w_repeat_pulse;
         r_state   <= w_state_nxt;
         r_rep_cnt <= w_rep_cnt_nxt;
      end
   end

   assign o_held    = r_held;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_repeat  = r_repeat;
   assign o_event   = r_event;

endmodule

// File: rtl/btn_input_unit.sv
// Five-button input conditioning: one independent btn_channel per pad, raw
// active-low pads in, single-cycle press/release/repeat/event strobes out.
module btn_input_unit
   import btn_input_unit_pkg::*;
#(
   parameter int               N_BTN         = N_BTN_DEF,
   parameter int               DEB_CYCLES    = DEB_CYCLES_DEF,
   parameter int               REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int               REPEAT_PERIOD = REPEAT_PERIOD_DEF,
   parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(REPEAT_MASK_DEF)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_BTN-1:0] i_btn_raw,
   output logic [N_BTN-1:0] o_btn_held,
   output logic [N_BTN-1:0] o_btn_press,
   output logic [N_BTN-1:0] o_btn_release,
   output logic [N_BTN-1:0] o_btn_repeat,
   output logic [N_BTN-1:0] o_btn_event
);

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_channel #(
         .DEB_CYCLES    (DEB_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_repeat_en (REPEAT_MASK[g]),
         .i_btn_raw_n (i_btn_raw[g]),
         .o_held      (o_btn_held[g]),
         .o_press     (o_btn_press[g]),
         .o_release   (o_btn_release[g]),
         .o_repeat    (o_btn_repeat[g]),
         .o_event     (o_btn_event[g])
      );
   end

endmodule

// File: tb/tb_btn_input_unit.sv
// Directed bench for btn_input_unit with DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Inputs change on the falling edge; the next rising edge samples them and is edge 0.
module tb_btn_input_unit;
   import btn_input_unit_pkg::*;

   localparam int N = 5;

   logic         clk;
   logic         rst;
   logic [N-1:0] raw;
   logic [N-1:0] held, press, rel, rep, evt;

   int n_pass  = 0;
   int n_total = 0;

   btn_input_unit #(
      .N_BTN         (N),
      .DEB_CYCLES    (4),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (3),
      .REPEAT_MASK   (5'b01111)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_btn_raw     (raw),
      .o_btn_held    (held),
      .o_btn_press   (press),
      .o_btn_release (rel),
      .o_btn_repeat  (rep),
      .o_btn_event   (evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [N-1:0] bit_if(input bit c, input int idx);
      logic [N-1:0] one;
      one = 5'b00001;
      return c ? (one << idx) : 5'b00000;
   endfunction

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
   endtask

   task automatic check_all(input string tag, input int e, input logic [N-1:0] e_held,
                            input logic [N-1:0] e_press, input logic [N-1:0] e_rel,
                            input logic [N-1:0] e_rep);
      chk($sformatf("%s e%0d held", tag, e), held, e_held);
      chk($sformatf("%s e%0d press", tag, e), press, e_press);
      chk($sformatf("%s e%0d release", tag, e), rel, e_rel);
      chk($sformatf("%s e%0d repeat", tag, e), rep, e_rep);
      chk($sformatf("%s e%0d event", tag, e), evt, e_press | e_rep);
   endtask

   initial begin
      logic [N-1:0] z;
      z   = 5'b00000;
      rst = 1'b1;
      raw = 5'b11111;

      // 1: reset, then 50 quiet cycles
      for (int e = 0; e < 3; e++) begin
         tick();
         check_all("rst_hold", e, z, z, z, z);
      end
      rst = 1'b0;
      for (int e = 0; e < 50; e++) begin
         tick();
         check_all("idle", e, z, z, z, z);
      end

      // 2: DOWN press, repeats, then release (driven after edge 25)
      raw = 5'b11101;
      for (int e = 0; e <= 40; e++) begin
         tick();
         check_all("down", e,
            bit_if(e >= 6 && e <= 31, BTN_DOWN),
            bit_if(e == 6, BTN_DOWN),
            bit_if(e == 32, BTN_DOWN),
            bit_if(e >= 16 && e <= 31 && (e - 16) % 3 == 0, BTN_DOWN));
         if (e == 25) raw = 5'b11111;
      end

      // 3: 3-low/2-high glitch train on LEFT never gets through
      for (int i = 0; i < 40; i++) begin
         raw = {4'b1111, ((i % 5) < 3) ? 1'b0 : 1'b1};
         tick();
         check_all("glitch", i, z, z, z, z);
      end
      raw = 5'b11111;
      for (int e = 0; e < 8; e++) begin
         tick();
         check_all("glitch_tail", e, z, z, z, z);
      end

      // 4: ENTER held 40 cycles is masked from repeating; release pulse 6 edges later
      raw = 5'b01111;
      for (int e = 0; e <= 50; e++) begin
         tick();
         check_all("enter", e,
            bit_if(e >= 6 && e <= 45, BTN_ENTER),
            bit_if(e == 6, BTN_ENTER),
            bit_if(e == 46, BTN_ENTER),
            z);
         if (e == 39) raw = 5'b11111;
      end

      // 5: UP+RIGHT together; UP released so its release lands on a terminal count
      raw = 5'b10011;
      for (int e = 0; e <= 45; e++) begin
         tick();
         check_all("up_right", e,
            bit_if(e >= 6 && e <= 24, BTN_UP) | bit_if(e >= 6 && e <= 38, BTN_RIGHT),
            bit_if(e == 6, BTN_UP) | bit_if(e == 6, BTN_RIGHT),
            bit_if(e == 25, BTN_UP) | bit_if(e == 39, BTN_RIGHT),
            bit_if(e == 16 || e == 19 || e == 22, BTN_UP)
               | bit_if(e >= 16 && e <= 37 && (e - 16) % 3 == 0, BTN_RIGHT));
         if (e == 18) raw = 5'b11011;
         if (e == 32) raw = 5'b11111;
      end

      // 6: reset in REPEAT state, button still held across reset release
      raw = 5'b11101;
      for (int e = 0; e <= 20; e++) begin
         tick();
         check_all("pre_rst", e,
            bit_if(e >= 6, BTN_DOWN),
            bit_if(e == 6, BTN_DOWN),
            z,
            bit_if(e >= 16 && (e - 16) % 3 == 0, BTN_DOWN));
      end
      rst = 1'b1;
      #1;
      check_all("rst_async", 0, z, z, z, z);
      for (int e = 0; e < 3; e++) begin
         tick();
         check_all("rst_mid", e, z, z, z, z);
      end
      rst = 1'b0;
      for (int e = 0; e <= 42; e++) begin
         tick();
         check_all("post_rst", e,
            bit_if(e >= 6 && e <= 36, BTN_DOWN),
            bit_if(e == 6, BTN_DOWN),
            bit_if(e == 37, BTN_DOWN),
            bit_if(e >= 16 && e <= 34 && (e - 16) % 3 == 0, BTN_DOWN));
         if (e == 30) raw = 5'b11111;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
